// File: rtl/depth_clear_sequencer.sv
// rtl/depth_clear_sequencer.sv - frame-level depth buffer clear sweep and pixel-write gate
// Optional stall perf counter: define DEPTH_CLEAR_PERF_EN.
module depth_clear_sequencer #(
   parameter int  BUFFER_WIDTH      = 160,
   parameter int  BUFFER_HEIGHT     = 120,
   parameter int  BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT),
   parameter int  DRAIN_CYCLES      = 3,
   parameter type pixel_data_t      = logic [47:0]
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         frame_start,
   input  logic                         pix_valid,
   output logic                         pix_ready,
   input  logic [BUFFER_ADDR_WIDTH-1:0] pix_addr,
   input  pixel_data_t                  pix_data,
   output logic                         write_req,
   output logic [BUFFER_ADDR_WIDTH-1:0] write_addr,
   output pixel_data_t                  write_pixel,
   output logic                         clear_req,
   output logic [BUFFER_ADDR_WIDTH-1:0] clear_addr,
   output logic                         clear_busy,
   output logic                         clear_done,
   output logic                         frame_overrun,
   output logic [31:0]                  stall_cycles
);

   localparam int N  = BUFFER_WIDTH * BUFFER_HEIGHT;
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [BUFFER_ADDR_WIDTH-1:0] LAST_ADDR  = BUFFER_ADDR_WIDTH'(N - 1);
   localparam logic [DW-1:0]                DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_CLEAR
   } state_t;

   state_t                         state_q, state_d;
   logic [DW-1:0]                  drain_cnt_q, drain_cnt_d;
   logic [BUFFER_ADDR_WIDTH-1:0]   clear_cnt_q, clear_cnt_d;
   logic                           pending_q, pending_d;
   logic                           clear_req_q, clear_req_d;
   logic                           clear_done_q, clear_done_d;
   logic                           overrun_q, overrun_d;
   logic                           clear_busy_q;
   logic                           write_req_q;
   logic [BUFFER_ADDR_WIDTH-1:0]   write_addr_q;
   pixel_data_t                    write_pixel_q;
   logic                           accept;

   assign pix_ready = (state_q == ST_IDLE);
   assign accept    = pix_valid && pix_ready;

   always_comb begin
      state_d      = state_q;
      drain_cnt_d  = drain_cnt_q;
      clear_cnt_d  = clear_cnt_q;
      pending_d    = pending_q;
      clear_req_d  = 1'b0;
      clear_done_d = 1'b0;
      overrun_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = '0;
            end
         end
         ST_DRAIN: begin
            if (frame_start) begin
               if (pending_q) overrun_d = 1'b1;
               else           pending_d = 1'b1;
            end
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d     = ST_CLEAR;
               clear_cnt_d = '0;
               clear_req_d = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + DW'(1);
            end
         end
         ST_CLEAR: begin
            // clear_done_q marks the trailing cycle after the last address
            if (clear_done_q) begin
               overrun_d   = frame_start && pending_q;
               pending_d   = 1'b0;
               drain_cnt_d = '0;
               state_d     = (pending_q || frame_start) ? ST_DRAIN : ST_IDLE;
            end else begin
               if (frame_start) begin
                  if (pending_q) overrun_d = 1'b1;
                  else           pending_d = 1'b1;
               end
               if (clear_cnt_q == LAST_ADDR) begin
                  clear_done_d = 1'b1;
               end else begin
                  clear_cnt_d = clear_cnt_q + BUFFER_ADDR_WIDTH'(1);
                  clear_req_d = 1'b1;
               end
            end
         end
         default: state_d = ST_DRAIN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_DRAIN;
         drain_cnt_q  <= '0;
         clear_cnt_q  <= '0;
         pending_q    <= 1'b0;
         clear_req_q  <= 1'b0;
         clear_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         clear_busy_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         drain_cnt_q  <= drain_cnt_d;
         clear_cnt_q  <= clear_cnt_d;
         pending_q    <= pending_d;
         clear_req_q  <= clear_req_d;
         clear_done_q <= clear_done_d;
         overrun_q    <= overrun_d;
         clear_busy_q <= (state_d != ST_IDLE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_req_q   <= 1'b0;
         write_addr_q  <= '0;
         write_pixel_q <= '0;
      end else begin
         write_req_q <= accept;
         if (accept) begin
            write_addr_q  <= pix_addr;
            write_pixel_q <= pix_data;
         end
      end
   end

   assign write_req     = write_req_q;
   assign write_addr    = write_addr_q;
   assign write_pixel   = write_pixel_q;
   assign clear_req     = clear_req_q;
   assign clear_addr    = clear_cnt_q;
   assign clear_busy    = clear_busy_q;
   assign clear_done    = clear_done_q;
   assign frame_overrun = overrun_q;

`ifdef DEPTH_CLEAR_PERF_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (pix_valid && !pix_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_depth_clear_sequencer.sv
// tb/tb_depth_clear_sequencer.sv - randomized self-checking bench for depth_clear_sequencer
module tb_depth_clear_sequencer;

   localparam int W     = 160;
   localparam int H     = 120;
   localparam int N     = W * H;
   localparam int AW    = $clog2(N);
   localparam int DRAIN = 3;
   localparam int SWEEP = DRAIN + N + 1;
   localparam int PW    = 48;

   typedef logic [PW-1:0] pix_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_start;
   logic          pix_valid;
   logic          pix_ready;
   logic [AW-1:0] pix_addr;
   pix_t          pix_data;
   logic          write_req;
   logic [AW-1:0] write_addr;
   pix_t          write_pixel;
   logic          clear_req;
   logic [AW-1:0] clear_addr;
   logic          clear_busy;
   logic          clear_done;
   logic          frame_overrun;
   logic [31:0]   stall_cycles;

   always #5 clk = ~clk;

   depth_clear_sequencer #(
      .BUFFER_WIDTH (W),
      .BUFFER_HEIGHT(H),
      .DRAIN_CYCLES (DRAIN),
      .pixel_data_t (pix_t)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .frame_start  (frame_start),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_addr     (pix_addr),
      .pix_data     (pix_data),
      .write_req    (write_req),
      .write_addr   (write_addr),
      .write_pixel  (write_pixel),
      .clear_req    (clear_req),
      .clear_addr   (clear_addr),
      .clear_busy   (clear_busy),
      .clear_done   (clear_done),
      .frame_overrun(frame_overrun),
      .stall_cycles (stall_cycles)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: m_busy = cycles of unavailability still ahead in the current sweep
   // (DRAIN + N clears + done cycle), 0 means the pixel stream is open.
   int          m_busy;
   bit          m_pend;
   bit          m_wreq;
   bit          m_ovr;
   bit          m_fresh;
   logic [AW-1:0] m_waddr;
   pix_t        m_wpix;
   longint      m_stall;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy  = SWEEP;
         m_pend  = 1'b0;
         m_wreq  = 1'b0;
         m_ovr   = 1'b0;
         m_fresh = 1'b1;
         m_waddr = '0;
         m_wpix  = '0;
         m_stall = 0;
      end else begin
         m_wreq = pix_valid && (m_busy == 0);
         if (m_wreq) begin
            m_waddr = pix_addr;
            m_wpix  = pix_data;
         end
         if (pix_valid && (m_busy != 0) && (m_stall < 64'hFFFF_FFFF)) m_stall++;
         m_ovr = 1'b0;
         if (m_busy == 0) begin
            if (frame_start) m_busy = SWEEP;
         end else if (m_busy == 1) begin
            m_ovr  = m_pend && frame_start;
            m_busy = (m_pend || frame_start) ? SWEEP : 0;
            m_pend = 1'b0;
         end else begin
            m_busy--;
            if (frame_start) begin
               if (m_pend) m_ovr = 1'b1;
               else        m_pend = 1'b1;
            end
         end
         m_fresh = 1'b0;
      end
   end

   int rq_run = 0;

   always @(negedge clk) begin
      if (rst) begin
         check("rst_clear_req", clear_req, 0);
         check("rst_pix_ready", pix_ready, 0);
         rq_run = 0;
      end else begin
         check("pix_ready", pix_ready, m_busy == 0);
         check("clear_req", clear_req, (m_busy >= 2) && (m_busy <= N + 1));
         if ((m_busy >= 2) && (m_busy <= N + 1))
            check("clear_addr", clear_addr, 64'(N + 1 - m_busy));
         check("clear_done", clear_done, m_busy == 1);
         check("clear_busy", clear_busy, (m_busy != 0) && !m_fresh);
         check("write_req", write_req, m_wreq);
         check("write_addr", write_addr, m_waddr);
         check("write_pixel", write_pixel, m_wpix);
         check("frame_overrun", frame_overrun, m_ovr);
         check("req_overlap", clear_req && write_req, 0);
`ifdef DEPTH_CLEAR_PERF_EN
         check("stall_cycles", stall_cycles, m_stall);
`else
         check("stall_cycles", stall_cycles, 0);
`endif
         if (clear_req) rq_run++;
         if (clear_done) begin
            check("sweep_length", rq_run, 19200);
            rq_run = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic traffic(input int n);
      bit rdy;
      for (int i = 0; i < n; i++) begin
         rdy = pix_ready;
         step();
         if (!pix_valid || rdy) begin
            pix_valid = 1'($urandom_range(0, 1));
            pix_addr  = AW'($urandom_range(0, N - 1));
            pix_data  = PW'({$urandom, $urandom});
         end
      end
   endtask

   // which: 0 = pix_ready, 1 = clear_done, 2 = clear_req at address target
   task automatic wait_for(input int which, input int target, input int bound, input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < bound && !hit; i++) begin
         step();
         case (which)
            0:       hit = pix_ready;
            1:       hit = clear_done;
            default: hit = clear_req && (clear_addr == AW'(target));
         endcase
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL wait_%s actual=timeout required=event", name);
      end
   endtask

   initial begin
      rst         = 1'b1;
      frame_start = 1'b0;
      pix_valid   = 1'b1;
      pix_addr    = AW'(7);
      pix_data    = PW'({$urandom, $urandom});
      repeat (3) step();
      rst = 1'b0;

      // post-reset sweep with a rasterizer stalled throughout
      step();
      check("post_rst_drain0", clear_req, 0);
      step();
      check("post_rst_drain1", clear_req, 0);
      step();
      check("post_rst_first_req", clear_req, 1);
      check("post_rst_first_addr", clear_addr, 0);
      wait_for(0, 0, 20000, "reset_sweep");
`ifdef DEPTH_CLEAR_PERF_EN
      check("stall_literal", stall_cycles, 19204);
`else
      check("stall_literal", stall_cycles, 0);
`endif

      // stream of five pixels at 10..14
      step();
      for (int i = 0; i < 5; i++) begin
         pix_valid = 1'b1;
         pix_addr  = AW'(10 + i);
         pix_data  = PW'({$urandom, $urandom});
         step();
         check("stream_addr", write_addr, 10 + i);
      end
      pix_valid = 1'b0;
      traffic(150);

      // frame_start together with an accepted pixel
      pix_valid   = 1'b1;
      pix_addr    = AW'(1234);
      pix_data    = PW'({$urandom, $urandom});
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("fs_ready_low", pix_ready, 0);
      check("fs_fwd_req", write_req, 1);
      check("fs_fwd_addr", write_addr, 1234);
      step();
      step();
      check("fs_no_req_yet", clear_req, 0);
      step();
      check("fs_first_req", clear_req, 1);
      check("fs_first_addr", clear_addr, 0);

      // three frame_starts during the sweep
      wait_for(2, 100 + $urandom_range(0, 50), 1000, "fs1");
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("fs1_no_overrun", frame_overrun, 0);
      wait_for(2, 2000 + $urandom_range(0, 50), 3000, "fs2");
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      wait_for(2, 4000 + $urandom_range(0, 50), 3000, "fs3");
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("fs3_overrun", frame_overrun, 1);
      wait_for(1, 0, 20000, "sweep2_done");
      check("done_ready_low", pix_ready, 0);

      // pending re-clear interrupted by reset at address 5000
      wait_for(2, 5000, 30000, "addr5000");
      rst = 1'b1;
      #1;
      check("async_rst_req", clear_req, 0);
      step();
      step();
      rst = 1'b0;
      step();
      step();
      check("rerun_drain", clear_req, 0);
      step();
      check("rerun_first_req", clear_req, 1);
      check("rerun_first_addr", clear_addr, 0);

      // frame_start in the clear_done cycle forces another sweep
      wait_for(1, 0, 20000, "sweep4_done");
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("done_fs_redrain", pix_ready, 0);
      wait_for(0, 0, 20000, "sweep5");
      traffic(100);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
